// File: rtl/softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : softmax_max_sub
// Purpose  : Row-max search and (x - max) >>> SHIFT normalisation ahead of softmax.
// Revision : 1.0  initial release
// ============================================================================
module softmax_max_sub #(
    parameter int D_W   = 16,
    parameter int NUM   = 16,
    parameter int SHIFT = 2
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 I_START,
    input  logic [D_W*NUM-1:0]   I_DATA,
    output logic                 O_VLD,
    output logic [D_W*NUM-1:0]   O_DATA,
    output logic [D_W-1:0]       O_MAX
);

    localparam int             CW         = $clog2(NUM) + 1;
    localparam logic [CW-1:0]  C_LAST     = CW'(NUM - 1);
    localparam logic [D_W-1:0] C_MOST_NEG = {1'b1, {(D_W-1){1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_MAX  = 4'b0010,
        S_SUB  = 4'b0100,
        S_END  = 4'b1000
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [D_W*NUM-1:0]   buf_q, buf_d;
    logic [D_W-1:0]       max_q, max_d;
    logic                 vld_q, vld_d;
    logic [D_W*NUM-1:0]   data_q, data_d;
    logic [D_W-1:0]       omax_q, omax_d;

    logic [D_W-1:0]       w_word;
    logic signed [D_W:0]  w_diff;
    logic signed [D_W:0]  w_sh;
    logic [D_W-1:0]       w_res;

    // Word currently addressed by the counter, in both MAX and SUB phases.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < NUM; i++) begin
            if (cnt_q == CW'(i)) begin
                w_word = buf_q[D_W*i +: D_W];
            end
        end
    end

    // One extra bit holds the full difference; only negative overflow is possible.
    always_comb begin
        w_diff = $signed({w_word[D_W-1], w_word}) - $signed({max_q[D_W-1], max_q});
        w_sh   = w_diff >>> SHIFT;
        w_res  = (w_sh[D_W] != w_sh[D_W-1]) ? C_MOST_NEG : w_sh[D_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        max_d   = max_q;
        vld_d   = 1'b0;
        data_d  = data_q;
        omax_d  = omax_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                max_d = C_MOST_NEG;
                if (I_START) begin
                    buf_d   = I_DATA;
                    data_d  = '0;
                    state_d = S_MAX;
                end
            end
            S_MAX: begin
                if (!I_START) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    data_d  = '0;
                end else begin
                    if ($signed(w_word) > $signed(max_q)) begin
                        max_d = w_word;
                    end
                    if (cnt_q == C_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SUB;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_SUB: begin
                if (!I_START) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    data_d  = '0;
                end else begin
                    for (int i = 0; i < NUM; i++) begin
                        if (cnt_q == CW'(i)) begin
                            data_d[D_W*i +: D_W] = w_res;
                        end
                    end
                    if (cnt_q == C_LAST) begin
                        cnt_d   = '0;
                        omax_d  = max_q;
                        state_d = S_END;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_END: begin
                vld_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            max_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            omax_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            max_q   <= max_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            omax_q  <= omax_d;
        end
    end

    assign O_VLD  = vld_q;
    assign O_DATA = data_q;
    assign O_MAX  = omax_q;

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_max_sub
// Purpose  : Directed bench for softmax_max_sub (SHIFT=2 and SHIFT=0 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_softmax_max_sub;

    localparam int D_W = 16;
    localparam int NUM = 16;
    localparam int W   = D_W * NUM;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   din   = '0;
    logic           vld2, vld0;
    logic [W-1:0]   dat2, dat0;
    logic [D_W-1:0] max2, max0;

    int             vectors     = 0;
    int             miscompares = 0;
    logic [W-1:0]   exp_q[$];
    logic           prev_vld    = 1'b0;

    always #5 clk = ~clk;

    softmax_max_sub #(.D_W(D_W), .NUM(NUM), .SHIFT(2)) u_dut2 (
        .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_DATA(din),
        .O_VLD(vld2), .O_DATA(dat2), .O_MAX(max2)
    );

    softmax_max_sub #(.D_W(D_W), .NUM(NUM), .SHIFT(0)) u_dut0 (
        .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_DATA(din),
        .O_VLD(vld0), .O_DATA(dat0), .O_MAX(max0)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Reference: integer max, then floor((x - max) / 2^sh) clamped to the word range.
    task automatic model(input logic [W-1:0] row, input int sh,
                         output logic [D_W-1:0] mx, output logic [W-1:0] y);
        int m, x, d, p, q;
        m = -32768;
        for (int i = 0; i < NUM; i++) begin
            x = int'($signed(row[D_W*i +: D_W]));
            if (x > m) m = x;
        end
        p = 1 << sh;
        y = '0;
        for (int i = 0; i < NUM; i++) begin
            x = int'($signed(row[D_W*i +: D_W]));
            d = x - m;
            q = d / p;
            if (q * p != d) q = q - 1;
            if (q < -32768) q = -32768;
            y[D_W*i +: D_W] = q[D_W-1:0];
        end
        mx = m[D_W-1:0];
    endtask

    function automatic logic [W-1:0] rnd_row();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W-1:0] ramp_row();
        logic [W-1:0] r;
        for (int i = 0; i < NUM; i++) r[D_W*i +: D_W] = 16'(i * 64);
        return r;
    endfunction

    // Every valid pulse is checked against the oldest outstanding expected row.
    always @(negedge clk) begin
        logic [W-1:0]   row, e2, e0;
        logic [D_W-1:0] m2, m0;
        if (rst_n && (vld2 || vld0)) begin
            chk("vld_shift2", {255'd0, vld2}, 1);
            chk("vld_shift0", {255'd0, vld0}, 1);
            chk("pulse_width", {255'd0, prev_vld}, 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_vld: actual vld=1 required vld=0");
            end else begin
                row = exp_q.pop_front();
                model(row, 2, m2, e2);
                model(row, 0, m0, e0);
                chk("max_shift2", max2, m2);
                chk("data_shift2", dat2, e2);
                chk("max_shift0", max0, m0);
                chk("data_shift0", dat0, e0);
            end
        end
        prev_vld = vld2;
    end

    task automatic wait_vld(input bit scramble, output int k);
        @(posedge clk);
        k = 0;
        if (scramble) begin
            #1 din = rnd_row();
        end
        while (k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (scramble) din = rnd_row();
            if (vld2) break;
        end
    endtask

    task automatic run_row(input logic [W-1:0] row, input bit scramble);
        int k;
        @(negedge clk);
        din   = row;
        start = 1'b1;
        exp_q.push_back(row);
        wait_vld(scramble, k);
        chk("latency", k, 33);
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0]   row_same, row_spec, row_r;
        logic [W-1:0]   ey;
        logic [D_W-1:0] em;
        int             k;

        for (int i = 0; i < NUM; i++) row_same[D_W*i +: D_W] = 16'h0100;
        row_spec = '0;
        row_spec[15:0]  = 16'h8000;
        row_spec[31:16] = 16'h7FFF;

        // Pin the reference model with hand-worked values.
        model(ramp_row(), 2, em, ey);
        chk("model_ramp_max", em, 16'h03C0);
        chk("model_ramp_y0", ey[15:0], 16'hFF10);
        model(row_spec, 0, em, ey);
        chk("model_sat_y0", ey[15:0], 16'h8000);
        chk("model_sat_y2", ey[47:32], 16'h8001);

        repeat (3) @(negedge clk);
        chk("reset_vld", {254'd0, vld2, vld0}, 0);
        chk("reset_data2", dat2, 0);
        chk("reset_data0", dat0, 0);
        chk("reset_max", {max2, max0}, 0);
        rst_n = 1'b1;

        run_row(row_same, 1'b0);
        chk("same_max", max2, 16'h0100);
        chk("same_data", dat2, 0);

        run_row(ramp_row(), 1'b0);
        chk("ramp_max", max2, 16'h03C0);
        chk("ramp_y0", dat2[15:0], 16'hFF10);
        chk("ramp_y14", dat2[D_W*14 +: D_W], 16'hFFF0);
        chk("ramp_y15", dat2[D_W*15 +: D_W], 16'h0000);

        run_row(row_spec, 1'b0);
        chk("spec_y0_s2", dat2[15:0], 16'hC000);
        chk("spec_y1_s2", dat2[31:16], 16'h0000);
        chk("spec_y2_s2", dat2[47:32], 16'hE000);
        chk("spec_y0_s0", dat0[15:0], 16'h8000);
        chk("spec_y15_s0", dat0[D_W*15 +: D_W], 16'h8001);

        // Abort on the 10th S_MAX cycle.
        @(negedge clk);
        din   = row_same;
        start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_data", dat2, 0);
        chk("abort_max", max2, 16'h7FFF);
        repeat (2) @(negedge clk);
        run_row(ramp_row(), 1'b0);
        chk("restart_max", max2, 16'h03C0);

        // Input changes after the latch edge must be ignored.
        run_row(rnd_row(), 1'b1);

        // Asynchronous reset in the middle of S_SUB.
        @(negedge clk);
        din   = rnd_row();
        start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", {255'd0, vld2}, 0);
        chk("async_rst_data", dat2, 0);
        chk("async_rst_max", max2, 0);
        @(negedge clk);
        row_r = rnd_row();
        din   = row_r;
        repeat (3) exp_q.push_back(row_r);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_vld(1'b0, k);
            chk("backtoback_latency", k, 33);
        end
        start = 1'b0;

        repeat (40) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
